// File: rtl/ram_burst_reader.sv
// Burst read client for a 1-cycle registered-read RAM port: turns (addr, len) commands
// into sequential wrapping reads and streams the returned words out with a last flag.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  // Two-entry FIFO: the head entry drives the stream outputs directly, the skid entry
  // catches the word that returns while the head is stalled.
  logic                  head_valid_q, head_valid_d;
  logic                  head_last_q, head_last_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  skid_last_q, skid_last_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occ;
  logic [1:0] occ_after_pop;

  assign pop           = head_valid_q & m_ready;
  assign push          = inflight_q;
  assign occ           = 2'(head_valid_q) + 2'(skid_valid_q) + 2'(inflight_q);
  assign occ_after_pop = occ - 2'(pop);

  // Credit check counts the slot freed by this cycle's pop, so issue rate stays at one
  // word per cycle while the consumer keeps up.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    issue           = 1'b0;
    inflight_d      = 1'b0;
    inflight_last_d = inflight_last_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = {1'b0, cmd_len} + (ADDR_WIDTH+1)'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (occ_after_pop < 2'd2) begin
          issue           = 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = (rem_q == (ADDR_WIDTH+1)'(1));
          addr_d          = addr_q + ADDR_WIDTH'(1);
          rem_d           = rem_q - (ADDR_WIDTH+1)'(1);
          if (rem_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_valid_d = head_valid_q;
    head_last_d  = head_last_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    if (pop) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_last_d  = skid_last_q;
        head_data_d  = skid_data_q;
        skid_valid_d = push;
        if (push) begin
          skid_last_d = inflight_last_q;
          skid_data_d = ram_dout;
        end
      end else begin
        head_valid_d = push;
        if (push) begin
          head_last_d = inflight_last_q;
          head_data_d = ram_dout;
        end
      end
    end else if (push) begin
      if (!head_valid_q) begin
        head_valid_d = 1'b1;
        head_last_d  = inflight_last_q;
        head_data_d  = ram_dout;
      end else begin
        skid_valid_d = 1'b1;
        skid_last_d  = inflight_last_q;
        skid_data_d  = ram_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_valid_q    <= 1'b0;
      head_last_q     <= 1'b0;
      head_data_q     <= '0;
      skid_valid_q    <= 1'b0;
      skid_last_q     <= 1'b0;
      skid_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      head_valid_q    <= head_valid_d;
      head_last_q     <= head_last_d;
      head_data_q     <= head_data_d;
      skid_valid_q    <= skid_valid_d;
      skid_last_q     <= skid_last_d;
      skid_data_q     <= skid_data_d;
    end
  end

  // A returning word with both entries full and no pop would be lost.
  fifo_no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && head_valid_q && skid_valid_q));

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ram_en    = issue;
  assign ram_we    = 1'b0;
  assign ram_addr  = addr_q;
  assign m_valid   = head_valid_q;
  assign m_data    = head_data_q;
  assign m_last    = head_last_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: behavioural RAM, queue-based expected-word model,
// directed timing checks plus randomized backpressure.
module tb_ram_burst_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: stall, 1: always ready, 2: random 50%
  int ready_mode = 1;
  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            outstanding = 0;
  int            pop_cnt = 0;
  int            last_pop_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  // Reference: a command expands into its full list of addresses and words at accept
  // time; the DUT must consume those lists in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_addr_q.delete();
      outstanding = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_stable", 64'({m_valid, m_last, m_data}), 64'({1'b1, prev_last, prev_data}));
      if (ram_en) begin
        if (exp_addr_q.size() == 0) check("spurious_issue", 64'(1), 64'(0));
        else check("ram_addr", 64'(ram_addr), 64'(exp_addr_q.pop_front()));
        check("ram_we", 64'(ram_we), 64'(0));
      end
      outstanding = outstanding + int'(ram_en) - int'(m_valid && m_ready);
      if (ram_en) check("credit_le_2", 64'(outstanding <= 2), 64'(1));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("stale_pop", 64'(1), 64'(0));
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("m_data", 64'(m_data), 64'(w.data));
          check("m_last", 64'(m_last), 64'(w.last));
        end
        pop_cnt++;
        if (m_last) last_pop_cyc = cyc;
      end
      if (cmd_valid && cmd_ready) begin
        for (int i = 0; i <= int'(cmd_len); i++) begin
          logic [AW-1:0] a;
          a = cmd_addr + AW'(i);
          exp_q.push_back('{data: mem[a], last: (i == int'(cmd_len))});
          exp_addr_q.push_back(a);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic set_ready(input int mode);
    @(posedge clk);
    ready_mode = mode;
    #1;
  endtask

  // Returns in the cycle after the handshake; k is the handshake cycle.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l, output int k);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    k = -1;
    for (int t = 0; t < 5000 && k < 0; t++) begin
      @(negedge clk);
      if (cmd_ready) k = cyc;
    end
    check("cmd_accepted", 64'(k >= 0), 64'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    $display("cmd addr=%0d len=%0d accepted in cycle %0d", a, l, k);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      if (!busy && !m_valid) done = 1'b1;
    end
    check("idle_reached", 64'(done), 64'(1));
    @(posedge clk);
    #1;
    check("model_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int k, k2, base, n_en;
    bit found;

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    mem[5] = 32'hA5A5_0005;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({cmd_ready, busy, ram_en, ram_we}), 64'(4'b1000));
    check("rst_addr", 64'(ram_addr), 64'(0));
    check("rst_stream", 64'({m_valid, m_last, m_data}), 64'(0));
    rst = 1'b0;

    // Single word: exact latency and return to idle
    set_ready(1);
    send_cmd(10'd5, 10'd0, k);
    @(negedge clk);
    check("k1_issue", 64'({busy, ram_en, ram_addr}), 64'({1'b1, 1'b1, 10'd5}));
    @(negedge clk);
    check("k2_no_valid", 64'(m_valid), 64'(0));
    @(negedge clk);
    check("k3_word", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b1, 32'hA5A5_0005}));
    @(negedge clk);
    check("k4_idle", 64'({busy, cmd_ready}), 64'(2'b01));
    wait_idle(50);

    // Wrap-around, one word per cycle
    send_cmd(10'd1022, 10'd3, k);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_stream", 64'({m_valid, m_last}), 64'({1'b1, i == 3}));
    end
    wait_idle(50);

    // Backpressure: only two reads may be outstanding
    set_ready(0);
    send_cmd(10'd0, 10'd7, k);
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_en) n_en++;
    end
    check("bp_issue_count", 64'(n_en), 64'(2));
    check("bp_head", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b0, 32'd0}));
    set_ready(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bp_stream", 64'(m_valid), 64'(1));
    end
    wait_idle(50);

    // Full-depth burst under random backpressure
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    base = pop_cnt;
    set_ready(2);
    send_cmd(10'd0, 10'd1023, k);
    wait_idle(10000);
    check("full_count", 64'(pop_cnt - base), 64'(1024));
    set_ready(1);
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

    // Second command held off until the first burst's last word pops
    base = pop_cnt;
    send_cmd(10'd200, 10'd3, k);
    send_cmd(10'd100, 10'd1, k2);
    check("cmd2_accept_cycle", 64'(k2), 64'(last_pop_cyc + 1));
    wait_idle(50);
    check("two_burst_count", 64'(pop_cnt - base), 64'(6));

    // Asynchronous reset while word 3 of 8 is presented
    send_cmd(10'd40, 10'd7, k);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (m_valid && m_data == 32'd42) found = 1'b1;
    end
    check("word3_seen", 64'(found), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_ctrl", 64'({cmd_ready, busy, ram_en, ram_we}), 64'(4'b1000));
    check("arst_addr", 64'(ram_addr), 64'(0));
    check("arst_stream", 64'({m_valid, m_last, m_data}), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_idle", 64'({m_valid, busy, cmd_ready}), 64'(3'b001));
    base = pop_cnt;
    send_cmd(10'd10, 10'd0, k);
    wait_idle(50);
    check("post_rst_count", 64'(pop_cnt - base), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side client for one port of the team's synchronous single-clock RAM primitives (1-cycle registered read, output holds while the port is disabled). It accepts a burst command (start address, length), issues sequential RAM reads with address wrap-around, and delivers the returned words on a valid/ready stream with `m_last` on the final word. A 2-entry output buffer with credit-based issue lets it sustain one word per cycle and absorb arbitrary downstream backpressure without losing data.

## Interface
- `DATA_WIDTH`, 32, RAM word width.
- `ADDR_WIDTH`, 10, RAM address width; depth = 2^ADDR_WIDTH.

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  burst command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_addr`  in  ADDR_WIDTH  start address.
- `cmd_len`  in  ADDR_WIDTH  words minus one (0 → 1 word; all-ones → 2^ADDR_WIDTH words).
- `ram_en`  out  1  RAM port enable.
- `ram_we`  out  1  tied 0.
- `ram_addr`  out  ADDR_WIDTH  RAM read address.
- `ram_dout`  in  DATA_WIDTH  RAM read data, valid the cycle after `ram_en`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  final word of the burst.
- `busy`  out  1  high from command accept until the last word is popped.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. A handshake loads the address counter ← `cmd_addr` and the remaining-issue counter ← `cmd_len`+1 (ADDR_WIDTH+1 bits), then → RUN.
  - RUN: issue reads. When the final read issues → DRAIN.
  - DRAIN: no issues. When the `m_last` word pops → IDLE.
- `cmd_ready` = (state==IDLE). A command presented while busy is held off and is not accepted.
- Occupancy `occ` = buffered words + reads in flight (0/1). `pop` = `m_valid && m_ready`.
- Issue condition: state==RUN and (`occ` − `pop`) < 2. `ram_en` = issue, combinational (depends on `m_ready`). `ram_addr` = address counter, held when not issuing.
- On issue, the address counter increments modulo 2^ADDR_WIDTH (wraps at 2^ADDR_WIDTH−1 → 0) and the remaining count decrements.
- In-flight flag: set on issue, cleared the next cycle. When set, `ram_dout` is written into the 2-entry FIFO together with a last tag (the tag is set when the remaining count was 1 at issue).
- `m_data`, `m_last`, `m_valid` come from the FIFO head and are registered, not taken combinationally from `ram_dout`.
- The FIFO never overflows. The credit rule guarantees this. Overflow is a design error; verification asserts on it.
- `busy` = state≠IDLE.

## Timing
- Reset values: `cmd_ready`=1, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0. The FIFO, in-flight flag and counters are cleared.
- Reset mid-burst: all outputs take reset values immediately (asynchronous). In-flight data is discarded and the burst is abandoned.
- Command handshake in cycle k:
  - `busy`=1 and `ram_en`=1 (`ram_addr`=`cmd_addr`) in cycle k+1.
  - Data is captured at the end of cycle k+2.
  - First `m_valid`=1 in cycle k+3.
- Throughput: with `m_ready`=1 continuously, one word per cycle. An N-word burst shows `m_valid` in cycles k+3 … k+N+2.
- Return to idle: the `m_last` pop in cycle j gives `busy`=0 and `cmd_ready`=1 in cycle j+1. The next command can then be accepted in cycle j+1.
- Backpressure: with `m_ready`=0, at most 2 reads are outstanding or buffered. `m_valid`, `m_data` and `m_last` stay stable until popped.
- Simultaneous FIFO write and pop in the same cycle: occupancy is unchanged. Data order is preserved.

## Test plan
- Single word: RAM[5]=0xA5A5_0005; cmd addr=5, len=0 → one `ram_en` at addr 5; `m_valid` in cycle k+3 with `m_data`=0xA5A5_0005 and `m_last`=1; `busy` falls the cycle after the pop.
- Wrap: cmd addr=1022, len=3, RAM[i]=i → `ram_addr` sequence 1022, 1023, 0, 1; output 1022, 1023, 0, 1 on consecutive cycles; `m_last` only on the value 1.
- Backpressure: cmd addr=0, len=7, `m_ready`=0 for 20 cycles → exactly 2 `ram_en` pulses, then none; `m_valid`=1 with `m_data`=0 held stable. Then `m_ready`=1 → values 0..7 delivered in order, one per cycle, no loss or duplication.
- Random `m_ready` (50%) over a full-depth burst (addr=0, len=1023) → all 1024 words delivered in order; `m_last` only on word 1023; FIFO never exceeds 2 entries.
- Command while busy: assert `cmd_valid` continuously with a second command (addr=100, len=1) during a 4-word burst → second command accepted only in the cycle after the first burst's `m_last` pop; its data 100, 101 follows.
- Reset mid-burst: `rst` pulsed during word 3 of 8 → all outputs at reset values; a new command (addr=10, len=0) afterward returns RAM[10] with no stale words.
